serial_deserializer: RTL and testbench

Serial-in/parallel-out receiver for the datapath's universal shifter: it accepts the bit stream produced by the 8-bit parallel-load shifter running in shift-left or shift-right mode and reassembles it into `BUS_WIDTH`-bit words. It holds one completed word in an output register with a valid/ready handshake. It also flags overruns when the consumer stalls. It sits between the serial link and the word-wide consumer logic.

---
 rtl/serial_deserializer.sv | 243 ++++++++++++++++++++++++
 tb/tb_serial_deserializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
//
// Serial-in / parallel-out receiver. Reassembles the bit stream produced by
// the parallel-load universal shifter (shift-left = MSB first, shift-right =
// LSB first) into BUS_WIDTH-bit words. One completed word is held in an
// output register behind a valid/ready handshake. A word that completes while
// the output register is still occupied and not being consumed is dropped
// and flagged as an overrun.
//
// Optional feature (compile-time macro DESER_PARITY_EN):
//   Each word is followed by one even-parity bit. The word is handed off on
//   the parity bit. A parity failure still delivers the word but raises the
//   sticky parity_err_o flag. Without the macro, parity_err_o is tied to 0.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   serial_i      in   serial data bit
//   bit_valid_i   in   serial_i carries a bit this cycle
//   frame_i       in   frame active (level); bits accepted only while high
//   msb_first_i   in   bit order, 1 = MSB first; latched at frame start
//   data_o        out  completed word [BUS_WIDTH-1:0]
//   valid_o       out  data_o holds an unconsumed word
//   ready_i       in   consumer takes data_o this cycle when valid_o = 1
//   overrun_o     out  sticky: a completed word was dropped
//   parity_err_o  out  sticky: a word failed the parity check
//
// Both sticky flags clear on the next frame start (IDLE -> COLLECT).
// ---------------------------------------------------------------------------
module serial_deserializer #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_i,
    input  logic                 bit_valid_i,
    input  logic                 frame_i,
    input  logic                 msb_first_i,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 parity_err_o
);

    localparam int unsigned     CNT_W    = (BUS_WIDTH > 2) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   sr_q, sr_d;
    logic                   msb_q, msb_d;
    logic [BUS_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
`ifdef DESER_PARITY_EN
    logic                   perr_q, perr_d;
`endif

    // Shared decode
    logic                   frame_start;
    logic                   accept;
    logic                   last_data;
    logic                   msb_eff;
    logic [BUS_WIDTH-1:0]   sr_base;
    logic [BUS_WIDTH-1:0]   sr_shift;
    logic                   word_done;
    logic [BUS_WIDTH-1:0]   word;

    assign frame_start = (state_q == IDLE) && frame_i;
    assign accept      = frame_i && bit_valid_i;
    assign last_data   = accept && (state_q != PARITY) && (cnt_q == CNT_LAST);

    // On the frame-start edge the register contents are stale: shift the
    // first bit into a cleared register using the live bit-order input.
    assign msb_eff  = frame_start ? msb_first_i : msb_q;
    assign sr_base  = frame_start ? '0 : sr_q;
    assign sr_shift = msb_eff ? {sr_base[BUS_WIDTH-2:0], serial_i}
                              : {serial_i, sr_base[BUS_WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (frame_i) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!frame_i) begin
                    state_d = IDLE;
                end
`ifdef DESER_PARITY_EN
                else if (last_data) begin
                    state_d = PARITY;
                end
`endif
            end
            PARITY: begin
                if (!frame_i) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        msb_d     = msb_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
`ifdef DESER_PARITY_EN
        perr_d    = perr_q;
`endif
        word_done = 1'b0;
        word      = sr_shift;

        if (frame_start) begin
            msb_d = msb_first_i;
            cnt_d = '0;
            sr_d  = '0;
            ovr_d = 1'b0;
`ifdef DESER_PARITY_EN
            perr_d = 1'b0;
`endif
        end

        // Frame end discards any partial word; output register untouched.
        if ((state_q != IDLE) && !frame_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end

        if (accept) begin
`ifdef DESER_PARITY_EN
            if (state_q == PARITY) begin
                // The data bits are already complete in sr_q; the incoming
                // bit is the parity bit and is not shifted in.
                word_done = 1'b1;
                word      = sr_q;
                if ((^sr_q) ^ serial_i) begin
                    perr_d = 1'b1;
                end
            end else begin
                sr_d = sr_shift;
                cnt_d = last_data ? '0 : cnt_q + 1'b1;
            end
`else
            sr_d = sr_shift;
            if (last_data) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end

        // Output register hand-off. A consumer read and a new word on the
        // same edge is a continuous transfer, not an overrun.
        if (word_done) begin
            if (!valid_q || ready_i) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            msb_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            msb_q   <= msb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         serial_i;
    logic         bit_valid_i;
    logic         frame_i;
    logic         msb_first_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         overrun_o;
    logic         parity_err_o;

    int unsigned n_vec;
    int unsigned n_err;

    serial_deserializer #(.BUS_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_i     (serial_i),
        .bit_valid_i  (bit_valid_i),
        .frame_i      (frame_i),
        .msb_first_i  (msb_first_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: frame-level view. Bits of the current word are
    // kept in a queue; the word value is computed by positional weights.
    // ------------------------------------------------------------------
    bit           m_active;
    bit           m_msb;
    bit           m_bits[$];
    bit           m_ppend;
    int unsigned  m_pword;
    int unsigned  m_data;
    bit           m_valid;
    bit           m_ovr;
    bit           m_perr;

    task automatic model_reset();
        m_active = 0;
        m_msb    = 0;
        m_bits.delete();
        m_ppend  = 0;
        m_pword  = 0;
        m_data   = 0;
        m_valid  = 0;
        m_ovr    = 0;
        m_perr   = 0;
    endtask

    function automatic int unsigned assemble(input bit msb);
        int unsigned v = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (m_bits[i]) begin
                if (msb) v += 1 << (int'(W) - 1 - i);
                else     v += 1 << i;
            end
        end
        return v;
    endfunction

    task automatic model_step(input bit f, input bit b, input bit s,
                              input bit m, input bit r);
        bit          done = 0;
        int unsigned w    = 0;
        if (!m_active) begin
            if (f) begin
                m_active = 1;
                m_msb    = m;
                m_bits.delete();
                m_ppend  = 0;
                m_ovr    = 0;
                m_perr   = 0;
            end
        end else if (!f) begin
            m_active = 0;
            m_bits.delete();
            m_ppend  = 0;
        end
        if (f && b) begin
            if (m_ppend) begin
                w    = m_pword;
                done = 1;
                if ((($countones(w) + int'(s)) % 2) != 0) m_perr = 1;
                m_ppend = 0;
            end else begin
                m_bits.push_back(s);
                if (m_bits.size() == W) begin
                    w = assemble(m_msb);
                    m_bits.delete();
`ifdef DESER_PARITY_EN
                    m_ppend = 1;
                    m_pword = w;
`else
                    done = 1;
`endif
                end
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_data  = w;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (r) begin
            m_valid = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("data",    32'(data_o),       m_data);
        check("valid",   32'(valid_o),      32'(m_valid));
        check("overrun", 32'(overrun_o),    32'(m_ovr));
        check("perr",    32'(parity_err_o), 32'(m_perr));
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 ns later.
    task automatic cycle(input bit f, input bit b, input bit s,
                         input bit m, input bit r);
        frame_i     = f;
        bit_valid_i = b;
        serial_i    = s;
        msb_first_i = m;
        ready_i     = r;
        @(posedge clk);
        model_step(f, b, s, m, r);
        #1;
        check_outputs();
    endtask

    // Sends 8 bits, seq[7] first; with parity enabled a correct even
    // parity bit follows. ready_last applies to the completing bit.
    task automatic send_seq(input logic [7:0] seq, input bit msb,
                            input bit rdy, input bit rdy_last);
        logic [7:0] q = seq;
        for (int i = 7; i >= 0; i--) begin
`ifdef DESER_PARITY_EN
            cycle(1, 1, q[i], msb, rdy);
`else
            cycle(1, 1, q[i], msb, (i == 0) ? rdy_last : rdy);
`endif
        end
`ifdef DESER_PARITY_EN
        cycle(1, 1, ^q, msb, rdy_last);
`endif
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        serial_i    = 1'b0;
        bit_valid_i = 1'b0;
        frame_i     = 1'b0;
        msb_first_i = 1'b0;
        ready_i     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",  32'(data_o),       32'h0);
        check("rst_valid", 32'(valid_o),      32'h0);
        check("rst_ovr",   32'(overrun_o),    32'h0);
        check("rst_perr",  32'(parity_err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB-first word
        send_seq(8'b10110100, 1, 0, 0);
        check("msb_word",  32'(data_o),  32'hB4);
        check("msb_valid", 32'(valid_o), 32'h1);
        cycle(0, 0, 0, 0, 1);
        check("drain", 32'(valid_o), 32'h0);

        // LSB-first, same bit sequence
        send_seq(8'b10110100, 0, 0, 0);
        check("lsb_word", 32'(data_o), 32'h2D);
        cycle(0, 0, 0, 1, 1);

        // Stall and overrun
        send_seq(8'h11, 1, 0, 0);
        send_seq(8'h22, 1, 0, 0);
        check("stall_data", 32'(data_o),    32'h11);
        check("stall_ovr",  32'(overrun_o), 32'h1);
        cycle(0, 0, 0, 1, 0);
        check("ovr_sticky", 32'(overrun_o), 32'h1);
        cycle(1, 0, 0, 1, 0);
        check("ovr_clear",  32'(overrun_o), 32'h0);

        // Continuous transfer: 0x11 consumed on the edge 0x22 completes
        cycle(1, 0, 0, 1, 1);
        send_seq(8'h11, 1, 0, 0);
        send_seq(8'h22, 1, 0, 1);
        check("cont_data",  32'(data_o),    32'h22);
        check("cont_valid", 32'(valid_o),   32'h1);
        check("cont_ovr",   32'(overrun_o), 32'h0);

        // Frame drop mid-word
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        send_seq(8'hC3, 1, 0, 0);
        check("drop_data", 32'(data_o), 32'hC3);

        // Asynchronous reset mid-word
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        check("arst_data",  32'(data_o),    32'h0);
        check("arst_valid", 32'(valid_o),   32'h0);
        check("arst_ovr",   32'(overrun_o), 32'h0);
        model_reset();
        frame_i     = 1'b0;
        bit_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DESER_PARITY_EN
        // Good parity then bad parity on 0xB4 (four ones, even)
        for (int i = 7; i >= 0; i--) cycle(1, 1, (8'hB4 >> i) & 1, 1, 0);
        cycle(1, 1, 0, 1, 0);
        check("par_ok_data", 32'(data_o),       32'hB4);
        check("par_ok_err",  32'(parity_err_o), 32'h0);
        cycle(0, 0, 0, 1, 1);
        for (int i = 7; i >= 0; i--) cycle(1, 1, (8'hB4 >> i) & 1, 1, 0);
        cycle(1, 1, 1, 1, 0);
        check("par_bad_data",  32'(data_o),       32'hB4);
        check("par_bad_valid", 32'(valid_o),      32'h1);
        check("par_bad_err",   32'(parity_err_o), 32'h1);
        cycle(0, 0, 0, 1, 1);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit f, b, s, m, r;
            f = ($urandom_range(0, 99) < 94);
            b = ($urandom_range(0, 99) < 75);
            s = 1'($urandom);
            m = 1'($urandom);
            r = ($urandom_range(0, 99) < 40);
            cycle(f, b, s, m, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
